alu_op_sequencer: RTL and testbench

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

---
 rtl/alu_op_sequencer_if.sv | 57 +++++
 rtl/alu_op_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_if.sv
// Bundles the request, ALU drive/result and downstream result handshakes of alu_op_sequencer.
interface alu_op_sequencer_if #(
   parameter int WIDTH   = 8,
   parameter int C_WIDTH = 4
);
   logic                 s_valid;
   logic                 s_ready;
   logic [WIDTH-1:0]     s_opa;
   logic [WIDTH-1:0]     s_opb;
   logic                 s_cin;
   logic                 s_mode;
   logic [C_WIDTH-1:0]   s_cmd;
   logic [1:0]           s_inv;

   logic [WIDTH-1:0]     opa;
   logic [WIDTH-1:0]     opb;
   logic                 cin;
   logic                 mode;
   logic [C_WIDTH-1:0]   cmd;
   logic [1:0]           in_valid;
   logic                 ce;

   logic [WIDTH:0]       res;
   logic [2*WIDTH-1:0]   mul_res;
   logic                 cout;
   logic                 oflow;
   logic                 g;
   logic                 e;
   logic                 l;
   logic                 err;

   logic                 m_valid;
   logic                 m_ready;
   logic [WIDTH:0]       m_res;
   logic [2*WIDTH-1:0]   m_mul_res;
   logic [5:0]           m_flags;
   logic                 m_mul;
   logic                 busy;

   modport slave (
      input  s_valid, s_opa, s_opb, s_cin, s_mode, s_cmd, s_inv,
      input  res, mul_res, cout, oflow, g, e, l, err,
      input  m_ready,
      output s_ready,
      output opa, opb, cin, mode, cmd, in_valid, ce,
      output m_valid, m_res, m_mul_res, m_flags, m_mul, busy
   );

   modport master (
      output s_valid, s_opa, s_opb, s_cin, s_mode, s_cmd, s_inv,
      output res, mul_res, cout, oflow, g, e, l, err,
      output m_ready,
      input  s_ready,
      input  opa, opb, cin, mode, cmd, in_valid, ce,
      input  m_valid, m_res, m_mul_res, m_flags, m_mul, busy
   );
endinterface

// File: rtl/alu_op_sequencer.sv
// Queues ALU requests in a small FIFO and issues them one at a time to a fixed-latency ALU,
// holding the operands until the registered result can be handed downstream.
module alu_op_sequencer #(
   parameter int WIDTH   = 8,
   parameter int C_WIDTH = 4,
   parameter int DEPTH   = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   alu_op_sequencer_if.slave    bus
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int PW = 2*WIDTH + C_WIDTH + 4;
   localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;

   localparam logic [C_WIDTH-1:0] CMD_MUL_A = C_WIDTH'(9);
   localparam logic [C_WIDTH-1:0] CMD_MUL_B = C_WIDTH'(10);

   logic [PW-1:0]        r_mem [DEPTH];
   logic [AW-1:0]        r_wrPtr;
   logic [AW-1:0]        r_rdPtr;
   logic [AW:0]          r_count;

   logic [1:0]           r_state;
   logic [1:0]           r_latCnt;
   logic                 r_isMul;

   logic [WIDTH-1:0]     r_opa;
   logic [WIDTH-1:0]     r_opb;
   logic                 r_cin;
   logic                 r_mode;
   logic [C_WIDTH-1:0]   r_cmd;
   logic [1:0]           r_inValid;
   logic                 r_ce;

   logic                 r_mValid;
   logic [WIDTH:0]       r_mRes;
   logic [2*WIDTH-1:0]   r_mMulRes;
   logic [5:0]           r_mFlags;
   logic                 r_mMul;

   logic                 w_sReady;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_done;
   logic                 w_capture;
   logic                 w_headIsMul;
   logic [WIDTH-1:0]     w_hOpa;
   logic [WIDTH-1:0]     w_hOpb;
   logic                 w_hCin;
   logic                 w_hMode;
   logic [C_WIDTH-1:0]   w_hCmd;
   logic [1:0]           w_hInv;

   assign w_sReady = (r_count < C_DEPTH);
   assign w_push   = bus.s_valid && w_sReady;
   assign w_pop    = (r_state == ST_IDLE) && (r_count != '0);

   assign {w_hOpa, w_hOpb, w_hCin, w_hMode, w_hCmd, w_hInv} = r_mem[r_rdPtr];
   assign w_headIsMul = w_hMode && ((w_hCmd == CMD_MUL_A) || (w_hCmd == CMD_MUL_B));

   // The result is due on the last WAIT edge; HOLD simply re-tries that edge until downstream frees up.
   assign w_done    = ((r_state == ST_WAIT) && (r_latCnt == 2'd1)) || (r_state == ST_HOLD);
   assign w_capture = w_done && (!r_mValid || bus.m_ready);

   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wrPtr] <= {bus.s_opa, bus.s_opb, bus.s_cin, bus.s_mode, bus.s_cmd, bus.s_inv};
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wrPtr <= r_wrPtr + 1'b1;
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= ST_IDLE;
         r_latCnt  <= 2'd0;
         r_isMul   <= 1'b0;
         r_opa     <= '0;
         r_opb     <= '0;
         r_cin     <= 1'b0;
         r_mode    <= 1'b0;
         r_cmd     <= '0;
         r_inValid <= 2'b00;
         r_ce      <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_pop) begin
                  r_opa     <= w_hOpa;
                  r_opb     <= w_hOpb;
                  r_cin     <= w_hCin;
                  r_mode    <= w_hMode;
                  r_cmd     <= w_hCmd;
                  r_inValid <= w_hInv;
                  r_ce      <= 1'b1;
                  r_isMul   <= w_headIsMul;
                  r_latCnt  <= w_headIsMul ? 2'd3 : 2'd2;
                  r_state   <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (r_latCnt != 2'd1) begin
                  r_latCnt <= r_latCnt - 2'd1;
               end else begin
                  r_latCnt <= 2'd0;
                  if (w_capture) begin
                     r_ce    <= 1'b0;
                     r_state <= ST_IDLE;
                  end else begin
                     r_state <= ST_HOLD;
                  end
               end
            end
            ST_HOLD: begin
               if (w_capture) begin
                  r_ce    <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_ce    <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // A capture on the same edge as a downstream accept replaces the result, so M_VALID stays high.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_mValid  <= 1'b0;
         r_mRes    <= '0;
         r_mMulRes <= '0;
         r_mFlags  <= 6'd0;
         r_mMul    <= 1'b0;
      end else if (w_capture) begin
         r_mValid  <= 1'b1;
         r_mRes    <= bus.res;
         r_mMulRes <= bus.mul_res;
         r_mFlags  <= {bus.cout, bus.oflow, bus.g, bus.e, bus.l, bus.err};
         r_mMul    <= r_isMul;
      end else if (bus.m_ready) begin
         r_mValid  <= 1'b0;
      end
   end

   assign bus.s_ready   = w_sReady;
   assign bus.opa       = r_opa;
   assign bus.opb       = r_opb;
   assign bus.cin       = r_cin;
   assign bus.mode      = r_mode;
   assign bus.cmd       = r_cmd;
   assign bus.in_valid  = r_inValid;
   assign bus.ce        = r_ce;
   assign bus.m_valid   = r_mValid;
   assign bus.m_res     = r_mRes;
   assign bus.m_mul_res = r_mMulRes;
   assign bus.m_flags   = r_mFlags;
   assign bus.m_mul     = r_mMul;
   assign bus.busy      = (r_state != ST_IDLE) || (r_count != '0);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed vectors, a randomized run against a
// transaction-level model, and hand-written backpressure, full-FIFO and reset sequences.
module tb_alu_op_sequencer;

   typedef struct packed {
      logic [7:0] opa;
      logic [7:0] opb;
      logic       cin;
      logic       mode;
      logic [3:0] cmd;
      logic [1:0] inv;
   } req_t;

   typedef struct packed {
      req_t        req;
      logic [3:0]  lat;
      logic [8:0]  res;
      logic [15:0] mulRes;
      logic [5:0]  flags;
      logic        mul;
   } vec_t;

   logic i_clk;
   logic i_rst_n;
   int   nChecks;
   int   nFails;

   alu_op_sequencer_if #(.WIDTH(8), .C_WIDTH(4)) bus ();

   alu_op_sequencer #(.WIDTH(8), .C_WIDTH(4), .DEPTH(4)) dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .bus     (bus)
   );

   // Stand-in ALU: add with carry, full product, compare flags, and ERR for mode-0 commands 12..15.
   function automatic logic [8:0] aluRes(input logic [7:0] a, input logic [7:0] b, input logic c);
      return {1'b0, a} + {1'b0, b} + {8'd0, c};
   endfunction

   function automatic logic [15:0] aluMul(input logic [7:0] a, input logic [7:0] b);
      return {8'd0, a} * {8'd0, b};
   endfunction

   function automatic logic [5:0] aluFlags(input logic [7:0] a, input logic [7:0] b, input logic c,
                                           input logic m, input logic [3:0] cm);
      logic [8:0] r;
      r = aluRes(a, b, c);
      return {r[8], (a[7] == b[7]) && (r[7] != a[7]), a > b, a == b, a < b, !m && (cm >= 4'd12)};
   endfunction

   function automatic logic isMulReq(input req_t r);
      return r.mode && (r.cmd == 4'd9 || r.cmd == 4'd10);
   endfunction

   function automatic int latOf(input req_t r);
      return isMulReq(r) ? 3 : 2;
   endfunction

   logic [5:0] aluF;
   assign aluF        = aluFlags(bus.opa, bus.opb, bus.cin, bus.mode, bus.cmd);
   assign bus.res     = aluRes(bus.opa, bus.opb, bus.cin);
   assign bus.mul_res = aluMul(bus.opa, bus.opb);
   assign {bus.cout, bus.oflow, bus.g, bus.e, bus.l, bus.err} = aluF;

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      nChecks++;
      if (actual !== expected) begin
         nFails++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
      end
   endtask

   task automatic checkResult(input string name, input req_t r);
      checkOutput({name, "_m_res"},     32'(bus.m_res),     32'(aluRes(r.opa, r.opb, r.cin)));
      checkOutput({name, "_m_mul_res"}, 32'(bus.m_mul_res), 32'(aluMul(r.opa, r.opb)));
      checkOutput({name, "_m_flags"},   32'(bus.m_flags),   32'(aluFlags(r.opa, r.opb, r.cin, r.mode, r.cmd)));
      checkOutput({name, "_m_mul"},     32'(bus.m_mul),     32'(isMulReq(r)));
   endtask

   task automatic applyStimulus(input req_t r, input logic v);
      bus.s_valid = v;
      bus.s_opa   = r.opa;
      bus.s_opb   = r.opb;
      bus.s_cin   = r.cin;
      bus.s_mode  = r.mode;
      bus.s_cmd   = r.cmd;
      bus.s_inv   = r.inv;
   endtask

   function automatic req_t randReq();
      req_t r;
      r.opa  = 8'($urandom);
      r.opb  = 8'($urandom);
      r.cin  = 1'($urandom);
      r.mode = 1'($urandom);
      r.cmd  = ($urandom_range(0, 3) == 0) ? 4'd9 : 4'($urandom);
      r.inv  = 2'($urandom);
      return r;
   endfunction

   task automatic doReset();
      req_t z;
      z = '0;
      applyStimulus(z, 1'b0);
      bus.m_ready = 1'b0;
      @(negedge i_clk);
      i_rst_n = 1'b0;
      repeat (2) @(negedge i_clk);
      i_rst_n = 1'b1;
   endtask

   // One isolated request: checks issue timing, drive values, result latency and payload.
   task automatic runVector(input vec_t v, input int idx);
      int got;
      string nm;
      nm = $sformatf("vec%0d", idx);
      @(negedge i_clk);
      applyStimulus(v.req, 1'b1);
      @(posedge i_clk);
      #1;
      applyStimulus(v.req, 1'b0);
      checkOutput({nm, "_ce_before_issue"}, 32'(bus.ce), 32'd0);
      got = 0;
      for (int c = 1; c <= 10; c++) begin
         @(posedge i_clk);
         #1;
         if (c == 1) begin
            checkOutput({nm, "_ce_issue"},       32'(bus.ce),       32'd1);
            checkOutput({nm, "_in_valid_issue"}, 32'(bus.in_valid), 32'(v.req.inv));
            checkOutput({nm, "_opa_issue"},      32'(bus.opa),      32'(v.req.opa));
            checkOutput({nm, "_cmd_issue"},      32'(bus.cmd),      32'(v.req.cmd));
         end
         if (bus.m_valid) begin
            got = c;
            break;
         end
      end
      checkOutput({nm, "_latency"},   32'(got),           32'(1 + v.lat));
      checkOutput({nm, "_m_res"},     32'(bus.m_res),     32'(v.res));
      checkOutput({nm, "_m_mul_res"}, 32'(bus.m_mul_res), 32'(v.mulRes));
      checkOutput({nm, "_m_flags"},   32'(bus.m_flags),   32'(v.flags));
      checkOutput({nm, "_m_mul"},     32'(bus.m_mul),     32'(v.mul));
      checkOutput({nm, "_ce_after"},  32'(bus.ce),        32'd0);
   endtask

   vec_t vecs [6];
   req_t modelQ [$];
   req_t expQ [$];
   req_t cur;
   req_t outReq;
   req_t item;
   bit   inflight;
   bit   outValid;
   bit   captured;
   bit   accepted;
   bit   sawValid;
   int   rem;
   int   drained;
   int   nextId;

   initial begin
      nChecks = 0;
      nFails  = 0;
      vecs[0] = '{req: '{8'h0F, 8'h02, 1'b0, 1'b1, 4'h0, 2'b01}, lat: 4'd2, res: 9'h011, mulRes: 16'h001E, flags: 6'b001000, mul: 1'b0};
      vecs[1] = '{req: '{8'h0F, 8'h02, 1'b0, 1'b1, 4'h9, 2'b11}, lat: 4'd3, res: 9'h011, mulRes: 16'h001E, flags: 6'b001000, mul: 1'b1};
      vecs[2] = '{req: '{8'h0F, 8'h02, 1'b0, 1'b1, 4'hA, 2'b00}, lat: 4'd3, res: 9'h011, mulRes: 16'h001E, flags: 6'b001000, mul: 1'b1};
      vecs[3] = '{req: '{8'h0F, 8'h02, 1'b0, 1'b0, 4'h9, 2'b01}, lat: 4'd2, res: 9'h011, mulRes: 16'h001E, flags: 6'b001000, mul: 1'b0};
      vecs[4] = '{req: '{8'hFF, 8'h01, 1'b1, 1'b1, 4'h3, 2'b11}, lat: 4'd2, res: 9'h101, mulRes: 16'h00FF, flags: 6'b101000, mul: 1'b0};
      vecs[5] = '{req: '{8'h80, 8'h80, 1'b0, 1'b0, 4'hC, 2'b10}, lat: 4'd2, res: 9'h100, mulRes: 16'h4000, flags: 6'b110101, mul: 1'b0};

      i_rst_n = 1'b0;
      item = '0;
      applyStimulus(item, 1'b0);
      bus.m_ready = 1'b0;
      #3;
      checkOutput("rst_ce",        32'(bus.ce),        32'd0);
      checkOutput("rst_opa",       32'(bus.opa),       32'd0);
      checkOutput("rst_in_valid",  32'(bus.in_valid),  32'd0);
      checkOutput("rst_m_valid",   32'(bus.m_valid),   32'd0);
      checkOutput("rst_m_mul_res", 32'(bus.m_mul_res), 32'd0);
      checkOutput("rst_busy",      32'(bus.busy),      32'd0);
      doReset();
      #1;
      checkOutput("rst_s_ready", 32'(bus.s_ready), 32'd1);

      bus.m_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         runVector(vecs[i], i);
      end

      // Randomized traffic against a transaction-level model of queue, single in-flight op and output slot.
      doReset();
      modelQ.delete();
      inflight = 0;
      outValid = 0;
      rem      = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         @(negedge i_clk);
         item = randReq();
         applyStimulus(item, 1'($urandom_range(0, 2) != 0));
         bus.m_ready = 1'($urandom_range(0, 3) != 0);
         checkOutput("rand_s_ready", 32'(bus.s_ready), 32'(modelQ.size() < 4));
         checkOutput("rand_busy",    32'(bus.busy),    32'(inflight || modelQ.size() != 0));
         accepted = bus.s_valid && (modelQ.size() < 4);
         captured = 0;
         if (!inflight) begin
            if (modelQ.size() != 0) begin
               cur      = modelQ.pop_front();
               inflight = 1;
               rem      = latOf(cur);
            end
         end else if (rem > 1) begin
            rem--;
         end else if (!outValid || bus.m_ready) begin
            outValid = 1;
            outReq   = cur;
            inflight = 0;
            captured = 1;
         end
         if (bus.m_ready && !captured) outValid = 0;
         if (accepted) modelQ.push_back(item);
         @(posedge i_clk);
         #1;
         checkOutput("rand_m_valid", 32'(bus.m_valid), 32'(outValid));
         checkOutput("rand_ce",      32'(bus.ce),      32'(inflight));
         if (outValid) checkResult("rand", outReq);
         if (inflight) checkOutput("rand_opa", 32'(bus.opa), 32'(cur.opa));
      end

      // Backpressure: fill until S_READY drops, then drain in order while pushing into a full FIFO.
      doReset();
      expQ.delete();
      nextId = 0;
      for (int c = 0; c < 40 && nextId < 6; c++) begin
         @(negedge i_clk);
         item = '{opa: 8'(8'h10 + nextId), opb: 8'h01, cin: 1'b0, mode: 1'b1, cmd: 4'h0, inv: 2'b01};
         applyStimulus(item, 1'b1);
         if (bus.s_ready) begin
            expQ.push_back(item);
            nextId++;
         end
      end
      @(negedge i_clk);
      applyStimulus(item, 1'b0);
      repeat (4) @(negedge i_clk);
      checkOutput("bp_pushed",    32'(nextId),      32'd6);
      checkOutput("bp_s_ready",   32'(bus.s_ready), 32'd0);
      checkOutput("bp_m_valid",   32'(bus.m_valid), 32'd1);
      checkOutput("bp_hold_ce",   32'(bus.ce),      32'd1);
      checkOutput("bp_hold_opa",  32'(bus.opa),     32'h11);
      checkOutput("bp_busy",      32'(bus.busy),    32'd1);

      drained = 0;
      bus.m_ready = 1'b1;
      for (int k = 0; k < 80; k++) begin
         if (k > 0) @(negedge i_clk);
         if (k == 1) checkOutput("full_pop_s_ready_before", 32'(bus.s_ready), 32'd0);
         if (k == 2) checkOutput("full_pop_s_ready_after",  32'(bus.s_ready), 32'd1);
         if (bus.m_valid) begin
            if (expQ.size() == 0) begin
               checkOutput("drain_extra_result", 32'd1, 32'd0);
            end else begin
               checkResult($sformatf("drain%0d", drained), expQ.pop_front());
               drained++;
            end
         end
         item = '{opa: 8'(8'h10 + nextId), opb: 8'h01, cin: 1'b0, mode: 1'b1, cmd: 4'h0, inv: 2'b00};
         applyStimulus(item, 1'(k < 5));
         if (bus.s_valid && bus.s_ready) begin
            expQ.push_back(item);
            nextId++;
         end
         if (k >= 5 && expQ.size() == 0 && !bus.m_valid) break;
      end
      applyStimulus(item, 1'b0);
      checkOutput("drain_left",  32'(expQ.size()), 32'd0);
      checkOutput("drain_count", 32'(drained),     32'(nextId));
      @(negedge i_clk);
      checkOutput("drain_busy",  32'(bus.busy),    32'd0);

      // Reset while a multiply is in WAIT with two requests queued behind it.
      doReset();
      bus.m_ready = 1'b1;
      @(negedge i_clk);
      applyStimulus('{8'h0F, 8'h02, 1'b0, 1'b1, 4'h9, 2'b11}, 1'b1);
      @(negedge i_clk);
      applyStimulus('{8'h21, 8'h03, 1'b0, 1'b1, 4'h0, 2'b01}, 1'b1);
      @(negedge i_clk);
      applyStimulus('{8'h22, 8'h04, 1'b0, 1'b1, 4'h0, 2'b01}, 1'b1);
      @(negedge i_clk);
      applyStimulus('{8'h22, 8'h04, 1'b0, 1'b1, 4'h0, 2'b01}, 1'b0);
      checkOutput("mrst_ce_wait", 32'(bus.ce),   32'd1);
      checkOutput("mrst_busy_pre", 32'(bus.busy), 32'd1);
      i_rst_n = 1'b0;
      #1;
      checkOutput("mrst_ce",       32'(bus.ce),       32'd0);
      checkOutput("mrst_opa",      32'(bus.opa),      32'd0);
      checkOutput("mrst_mode",     32'(bus.mode),     32'd0);
      checkOutput("mrst_cmd",      32'(bus.cmd),      32'd0);
      checkOutput("mrst_in_valid", 32'(bus.in_valid), 32'd0);
      checkOutput("mrst_m_valid",  32'(bus.m_valid),  32'd0);
      checkOutput("mrst_busy",     32'(bus.busy),     32'd0);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      sawValid = 0;
      for (int c = 0; c < 15; c++) begin
         @(posedge i_clk);
         #1;
         if (bus.m_valid || bus.busy || bus.ce) sawValid = 1;
      end
      checkOutput("mrst_no_result", 32'(sawValid),    32'd0);
      checkOutput("mrst_s_ready",   32'(bus.s_ready), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
